// File: rtl/mem_1rw_sync_mask_write_byte_synth_if.sv
// Bus bundle for the single-port byte-masked synchronous RAM.
// The requester drives the access fields; the memory drives data_o.
interface mem_1rw_sync_mask_write_byte_synth_if #(
    parameter int addr_width_p = 6,
    parameter int data_width_p = 32
);
    localparam int write_mask_width_lp = data_width_p >> 3;

    logic                           v_i;
    logic                           w_i;
    logic [addr_width_p-1:0]        addr_i;
    logic [data_width_p-1:0]        data_i;
    logic [write_mask_width_lp-1:0] write_mask_i;
    logic [data_width_p-1:0]        data_o;

    modport master (
        output v_i,
        output w_i,
        output addr_i,
        output data_i,
        output write_mask_i,
        input  data_o
    );

    modport slave (
        input  v_i,
        input  w_i,
        input  addr_i,
        input  data_i,
        input  write_mask_i,
        output data_o
    );
endinterface

// File: rtl/mem_1rw_sync_mask_write_byte_synth.sv
// Generic single-port synchronous RAM with a per-byte write mask.
// One read or one write per cycle; reads return data one cycle after the
// read edge through a registered output. Storage is never reset.
// Out-of-range writes are dropped and out-of-range reads return zero.
// latch_last_read_p=1 holds data_o between reads; 0 clears it every
// cycle that does not follow a read.
// Optional simulation-only checks: define MEM_1RW_SYNC_MASK_WRITE_BYTE_CHECKS_EN.

`ifdef MEM_1RW_SYNC_MASK_WRITE_BYTE_CHECKS_EN
`ifndef SYNTHESIS
module mem_1rw_sync_mask_write_byte_synth_checks #(
    parameter int els_p         = 64,
    parameter int data_width_p  = 32,
    parameter int addr_width_p  = 6
) (
    input logic                    clk_i,
    input logic                    reset_i,
    input logic                    v_i,
    input logic                    w_i,
    input logic [addr_width_p-1:0] addr_i
);
    // Report configuration once and reject widths that are not whole bytes.
    initial begin
        $display("%m: mem_1rw_sync_mask_write_byte_synth data_width_p=%0d els_p=%0d",
                 data_width_p, els_p);
        if ((data_width_p % 8) != 0) begin
            $error("%m: data_width_p=%0d is not a multiple of 8", data_width_p);
        end
    end

    // Flag undefined control and out-of-range addresses on valid accesses.
    always @(posedge clk_i) begin
        if (!reset_i && (v_i === 1'b1)) begin
            if ($isunknown(w_i) || $isunknown(addr_i)) begin
                $error("%m: X/Z on w_i or addr_i during a valid access");
            end else if (int'(addr_i) >= els_p) begin
                $error("%m: address %0d out of range (els_p=%0d)", addr_i, els_p);
            end
        end
    end
endmodule
`endif
`endif

module mem_1rw_sync_mask_write_byte_synth #(
    parameter int els_p             = 64,
    parameter int data_width_p      = 32,
    parameter int latch_last_read_p = 1
) (
    input logic clk_i,
    input logic reset_i,
    mem_1rw_sync_mask_write_byte_synth_if.slave bus
);
    localparam int addr_width_lp       = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int write_mask_width_lp = data_width_p >> 3;
    localparam logic [addr_width_lp:0] els_lp = (addr_width_lp + 1)'(els_p);

    // Byte-wise merge: masked bytes take the new data, the rest keep old data.
    function automatic logic [data_width_p-1:0] merge_bytes(
        input logic [data_width_p-1:0]        old_word,
        input logic [data_width_p-1:0]        new_word,
        input logic [write_mask_width_lp-1:0] mask
    );
        logic [data_width_p-1:0] merged;
        merged = old_word;
        for (int b = 0; b < write_mask_width_lp; b++) begin
            if (mask[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end else begin
                merged[8*b +: 8] = old_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

    logic [data_width_p-1:0] mem_r [els_p];
    logic [data_width_p-1:0] data_o_r;
    logic [data_width_p-1:0] rd_data_s;
    logic                    in_range_s;
    logic                    wr_en_s;
    logic                    rd_en_s;

    // Decode the access; reset blocks both reads and writes.
    always_comb begin
        in_range_s = 1'b0;
        wr_en_s    = 1'b0;
        rd_en_s    = 1'b0;
        rd_data_s  = '0;
        in_range_s = ({1'b0, bus.addr_i} < els_lp);
        wr_en_s    = bus.v_i & bus.w_i & in_range_s & ~reset_i;
        rd_en_s    = bus.v_i & ~bus.w_i;
        if (rd_en_s && in_range_s) begin
            rd_data_s = mem_r[bus.addr_i];
        end else begin
            rd_data_s = '0;
        end
    end

    // Storage array: masked byte write, contents intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_s) begin
            mem_r[bus.addr_i] <= merge_bytes(mem_r[bus.addr_i], bus.data_i, bus.write_mask_i);
        end
    end

    // Registered read port: load on read, then hold or clear by configuration.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            data_o_r <= '0;
        end else if (rd_en_s) begin
            data_o_r <= rd_data_s;
        end else if (latch_last_read_p == 0) begin
            data_o_r <= '0;
        end else begin
            data_o_r <= data_o_r;
        end
    end

    assign bus.data_o = data_o_r;

`ifdef MEM_1RW_SYNC_MASK_WRITE_BYTE_CHECKS_EN
`ifndef SYNTHESIS
    mem_1rw_sync_mask_write_byte_synth_checks #(
        .els_p        (els_p),
        .data_width_p (data_width_p),
        .addr_width_p (addr_width_lp)
    ) checks (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (bus.v_i),
        .w_i     (bus.w_i),
        .addr_i  (bus.addr_i)
    );
`endif
`else
    // Checks disabled: no simulation-only logic instantiated.
`endif
endmodule

// File: tb/tb_mem_1rw_sync_mask_write_byte_synth.sv
// Directed bench for mem_1rw_sync_mask_write_byte_synth.
// Three instances share one stimulus stream:
//   dut_a : els_p=64, latch_last_read_p=1
//   dut_b : els_p=64, latch_last_read_p=0
//   dut_c : els_p=10, latch_last_read_p=1 (low 4 address bits)
module tb_mem_1rw_sync_mask_write_byte_synth;
    logic        clk;
    logic        reset_i;
    logic        v;
    logic        w;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [3:0]  mask;

    int tests_run;
    int tests_failed;

    mem_1rw_sync_mask_write_byte_synth_if #(.addr_width_p(6), .data_width_p(32)) bus_a ();
    mem_1rw_sync_mask_write_byte_synth_if #(.addr_width_p(6), .data_width_p(32)) bus_b ();
    mem_1rw_sync_mask_write_byte_synth_if #(.addr_width_p(4), .data_width_p(32)) bus_c ();

    assign bus_a.v_i = v;
    assign bus_a.w_i = w;
    assign bus_a.addr_i = addr;
    assign bus_a.data_i = data;
    assign bus_a.write_mask_i = mask;
    assign bus_b.v_i = v;
    assign bus_b.w_i = w;
    assign bus_b.addr_i = addr;
    assign bus_b.data_i = data;
    assign bus_b.write_mask_i = mask;
    assign bus_c.v_i = v;
    assign bus_c.w_i = w;
    assign bus_c.addr_i = addr[3:0];
    assign bus_c.data_i = data;
    assign bus_c.write_mask_i = mask;

    mem_1rw_sync_mask_write_byte_synth #(.els_p(64), .data_width_p(32), .latch_last_read_p(1)) dut_a (
        .clk_i(clk), .reset_i(reset_i), .bus(bus_a));
    mem_1rw_sync_mask_write_byte_synth #(.els_p(64), .data_width_p(32), .latch_last_read_p(0)) dut_b (
        .clk_i(clk), .reset_i(reset_i), .bus(bus_b));
    mem_1rw_sync_mask_write_byte_synth #(.els_p(10), .data_width_p(32), .latch_last_read_p(1)) dut_c (
        .clk_i(clk), .reset_i(reset_i), .bus(bus_c));

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run = tests_run + 1;
        if (got !== exp) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic tv, input logic tw, input logic [5:0] ta,
                         input logic [31:0] td, input logic [3:0] tm);
        v = tv;
        w = tw;
        addr = ta;
        data = td;
        mask = tm;
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        reset_i = 1'b1;
        drive(1'b0, 1'b0, 6'd0, 32'h0, 4'h0);
        step();
        step();
        check_val("reset_a", bus_a.data_o, 32'h0);
        check_val("reset_b", bus_b.data_o, 32'h0);
        check_val("reset_c", bus_c.data_o, 32'h0);
        reset_i = 1'b0;

        // Seed addr 3 and read it back so data_o is nonzero.
        drive(1'b1, 1'b1, 6'd3, 32'hCAFEF00D, 4'hF);
        step();
        drive(1'b1, 1'b0, 6'd3, 32'h0, 4'h0);
        step();
        check_val("seed_rd_a", bus_a.data_o, 32'hCAFEF00D);
        check_val("seed_rd_b", bus_b.data_o, 32'hCAFEF00D);
        drive(1'b0, 1'b0, 6'd0, 32'h0, 4'h0);

        // Asynchronous reset mid-cycle clears data_o before the next edge.
        #2;
        reset_i = 1'b1;
        #1;
        check_val("async_rst_a", bus_a.data_o, 32'h0);
        check_val("async_rst_c", bus_c.data_o, 32'h0);
        // A write presented under reset must not land.
        drive(1'b1, 1'b1, 6'd3, 32'h12345678, 4'hF);
        step();
        check_val("rst_hold_a", bus_a.data_o, 32'h0);
        // First edge after release accepts the read.
        reset_i = 1'b0;
        drive(1'b1, 1'b0, 6'd3, 32'h0, 4'h0);
        step();
        check_val("rst_wr_drop_a", bus_a.data_o, 32'hCAFEF00D);
        check_val("rst_wr_drop_b", bus_b.data_o, 32'hCAFEF00D);
        check_val("rst_wr_drop_c", bus_c.data_o, 32'hCAFEF00D);

        // Full-word write then read.
        drive(1'b1, 1'b1, 6'd5, 32'hDEADBEEF, 4'hF);
        step();
        check_val("wr_keeps_out_a", bus_a.data_o, 32'hCAFEF00D);
        check_val("wr_clears_out_b", bus_b.data_o, 32'h0);
        drive(1'b1, 1'b0, 6'd5, 32'h0, 4'h0);
        step();
        check_val("full_wr_a", bus_a.data_o, 32'hDEADBEEF);
        check_val("full_wr_b", bus_b.data_o, 32'hDEADBEEF);

        // Partial mask 0101: bytes 0 and 2 updated.
        drive(1'b1, 1'b1, 6'd5, 32'h11223344, 4'b0101);
        step();
        drive(1'b1, 1'b0, 6'd5, 32'h0, 4'h0);
        step();
        check_val("mask_wr_a", bus_a.data_o, 32'hDE22BE44);
        check_val("mask_wr_c", bus_c.data_o, 32'hDE22BE44);

        // Hold behaviour across idle cycles and a write to the same address.
        drive(1'b1, 1'b0, 6'd5, 32'h0, 4'h0);
        step();
        check_val("hold_rd_a", bus_a.data_o, 32'hDE22BE44);
        check_val("hold_rd_b", bus_b.data_o, 32'hDE22BE44);
        drive(1'b0, 1'b0, 6'd0, 32'h0, 4'h0);
        step();
        check_val("idle1_a", bus_a.data_o, 32'hDE22BE44);
        check_val("idle1_b", bus_b.data_o, 32'h0);
        step();
        step();
        check_val("idle3_a", bus_a.data_o, 32'hDE22BE44);
        check_val("idle3_b", bus_b.data_o, 32'h0);
        drive(1'b1, 1'b1, 6'd5, 32'h0, 4'hF);
        step();
        check_val("wr_same_a", bus_a.data_o, 32'hDE22BE44);
        check_val("wr_same_b", bus_b.data_o, 32'h0);
        drive(1'b1, 1'b0, 6'd5, 32'h0, 4'h0);
        step();
        check_val("rd_new_a", bus_a.data_o, 32'h0);

        // All-zero mask is a no-op.
        drive(1'b1, 1'b1, 6'd5, 32'hFFFFFFFF, 4'h0);
        step();
        drive(1'b1, 1'b0, 6'd5, 32'h0, 4'h0);
        step();
        check_val("zero_mask_a", bus_a.data_o, 32'h0);
        check_val("zero_mask_b", bus_b.data_o, 32'h0);

        // Back-to-back write/read/write/read.
        drive(1'b1, 1'b1, 6'd0, 32'hA5A5A5A5, 4'hF);
        step();
        drive(1'b1, 1'b0, 6'd0, 32'h0, 4'h0);
        step();
        check_val("b2b_rd0_a", bus_a.data_o, 32'hA5A5A5A5);
        check_val("b2b_rd0_b", bus_b.data_o, 32'hA5A5A5A5);
        drive(1'b1, 1'b1, 6'd1, 32'h5A5A5A5A, 4'hF);
        step();
        check_val("b2b_wr1_a", bus_a.data_o, 32'hA5A5A5A5);
        check_val("b2b_wr1_b", bus_b.data_o, 32'h0);
        drive(1'b1, 1'b0, 6'd1, 32'h0, 4'h0);
        step();
        check_val("b2b_rd1_a", bus_a.data_o, 32'h5A5A5A5A);
        check_val("b2b_rd1_c", bus_c.data_o, 32'h5A5A5A5A);

        // Out-of-range on dut_c (els_p=10): addr 12 dropped, reads 0,
        // and must not alias onto addr 4.
        drive(1'b1, 1'b1, 6'd4, 32'h01020304, 4'hF);
        step();
        drive(1'b1, 1'b1, 6'd12, 32'h77778888, 4'hF);
        step();
        drive(1'b1, 1'b0, 6'd4, 32'h0, 4'h0);
        step();
        check_val("oor_alias_c", bus_c.data_o, 32'h01020304);
        check_val("in_rng_4_a", bus_a.data_o, 32'h01020304);
        drive(1'b1, 1'b0, 6'd12, 32'h0, 4'h0);
        step();
        check_val("oor_rd_c", bus_c.data_o, 32'h0);
        check_val("in_rng_12_a", bus_a.data_o, 32'h77778888);
        drive(1'b0, 1'b0, 6'd0, 32'h0, 4'h0);
        step();
        check_val("oor_hold_c", bus_c.data_o, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
